mem_loader: RTL and testbench

- Byte-stream program loader that acts as the write-side initiator for the 16-bit instruction/data memory port (address, data_in, write_en, read_en, data_out).
- Receives a framed image over an 8-bit valid/ready stream (from a debug UART or test host).
- Assembles big-endian 16-bit words and writes them into memory starting at a framed base address.
- Checks a trailing XOR checksum; reports completion or errors to the host.

---
 rtl/mem_loader.sv | 172 +++++++++++++++++
 tb/tb_mem_loader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// Byte-stream program loader: framed big-endian 16-bit image into a word memory, XOR-checksummed.
// Optional read-back pass of the loaded words is enabled by defining LOADER_VERIFY_EN.
module mem_loader #(
  parameter int MEM_DEPTH = 1024,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [15:0]       mem_wdata,
  output logic              mem_write_en,
  output logic              mem_read_en,
  input  logic [15:0]       mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [15:0]       words_written
);

  typedef enum logic [3:0] {
    HDR0, HDR1, HDR2, HDR3, DATA_HI, DATA_LO, WRITE, CHK, FIN
`ifdef LOADER_VERIFY_EN
    , VERIFY
`endif
  } state_t;

  state_t            state_q;
  logic [15:0]       base_q, cnt_q, idx_q, words_q;
  logic [7:0]        hi_q, xor_q;
  logic [1:0]        err_q;
  logic              range_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
`ifdef LOADER_VERIFY_EN
  logic [15:0]       wxor_q, racc_q;
`endif

  logic        acc;
  logic [15:0] cnt_d, idx_d;
  logic [16:0] end_d;

  assign in_ready = !rst && (state_q == HDR0 || state_q == HDR1 || state_q == HDR2 ||
                             state_q == HDR3 || state_q == DATA_HI || state_q == DATA_LO ||
                             state_q == CHK);
  assign acc   = in_valid && in_ready;
  assign cnt_d = {cnt_q[15:8], in_data};
  assign idx_d = idx_q + 16'd1;
  // 17-bit sum so base + count can never alias back into range
  assign end_d = {1'b0, base_q} + {1'b0, cnt_d};

  assign mem_address   = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_write_en  = (state_q == WRITE);
  assign busy          = (state_q != HDR0) && (state_q != FIN);
  assign done          = (state_q == FIN) && (err_q == 2'd0);
  assign error         = (state_q == FIN) && (err_q != 2'd0);
  assign err_code      = err_q;
  assign words_written = words_q;
`ifdef LOADER_VERIFY_EN
  assign mem_read_en = (state_q == VERIFY);
`else
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;
  assign mem_read_en  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HDR0;
      base_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      words_q <= '0;
      hi_q    <= '0;
      xor_q   <= '0;
      err_q   <= '0;
      range_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef LOADER_VERIFY_EN
      wxor_q  <= '0;
      racc_q  <= '0;
`endif
    end else begin
      case (state_q)
        HDR0: if (acc) begin
          base_q[15:8] <= in_data;
          xor_q        <= in_data;
          err_q        <= 2'd0;
          words_q      <= '0;
          state_q      <= HDR1;
        end
        HDR1: if (acc) begin
          base_q[7:0] <= in_data;
          xor_q       <= xor_q ^ in_data;
          state_q     <= HDR2;
        end
        HDR2: if (acc) begin
          cnt_q[15:8] <= in_data;
          xor_q       <= xor_q ^ in_data;
          state_q     <= HDR3;
        end
        HDR3: if (acc) begin
          cnt_q   <= cnt_d;
          xor_q   <= xor_q ^ in_data;
          range_q <= (end_d > 17'(MEM_DEPTH));
          idx_q   <= '0;
`ifdef LOADER_VERIFY_EN
          wxor_q  <= '0;
`endif
          state_q <= (cnt_d == 16'd0) ? CHK : DATA_HI;
        end
        DATA_HI: if (acc) begin
          hi_q    <= in_data;
          xor_q   <= xor_q ^ in_data;
          state_q <= DATA_LO;
        end
        DATA_LO: if (acc) begin
          xor_q <= xor_q ^ in_data;
          idx_q <= idx_d;
          // out-of-range frames are drained without touching memory
          if (range_q) begin
            state_q <= (idx_d == cnt_q) ? CHK : DATA_HI;
          end else begin
            addr_q  <= ADDR_W'(base_q + idx_q);
            wdata_q <= {hi_q, in_data};
            state_q <= WRITE;
          end
        end
        WRITE: begin
          words_q <= words_q + 16'd1;
`ifdef LOADER_VERIFY_EN
          wxor_q  <= wxor_q ^ wdata_q;
`endif
          state_q <= (idx_q == cnt_q) ? CHK : DATA_HI;
        end
        CHK: if (acc) begin
          if (range_q)               err_q <= 2'd1;
          else if (in_data != xor_q) err_q <= 2'd2;
          state_q <= FIN;
`ifdef LOADER_VERIFY_EN
          if (!range_q && in_data == xor_q && cnt_q != 16'd0) begin
            addr_q  <= ADDR_W'(base_q);
            idx_q   <= '0;
            racc_q  <= '0;
            state_q <= VERIFY;
          end
`endif
        end
`ifdef LOADER_VERIFY_EN
        VERIFY: begin
          racc_q <= racc_q ^ mem_rdata;
          if (idx_d == cnt_q) begin
            if ((racc_q ^ mem_rdata) != wxor_q) err_q <= 2'd3;
            state_q <= FIN;
          end else begin
            idx_q  <= idx_d;
            addr_q <= ADDR_W'(base_q + idx_d);
          end
        end
`endif
        FIN:     state_q <= HDR0;
        default: state_q <= HDR0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Randomised frame bench for mem_loader: frame-level reference model plus a per-cycle compare process.
module tb_mem_loader;
  localparam int DEPTH = 1024;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic        mem_write_en;
  logic        mem_read_en;
  logic [15:0] mem_rdata;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [15:0] words_written;

  mem_loader #(.MEM_DEPTH(DEPTH), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_write_en(mem_write_en),
    .mem_read_en(mem_read_en), .mem_rdata(mem_rdata), .busy(busy), .done(done),
    .error(error), .err_code(err_code), .words_written(words_written)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:DEPTH-1];
  bit          force_rd = 1'b0;
  assign mem_rdata = (force_rd && mem_read_en) ? 16'h0000 : mem[mem_address[9:0]];
  always @(posedge clk) if (mem_write_en) mem[mem_address[9:0]] <= mem_wdata;

  int          n_chk = 0, n_fail = 0, n_reads = 0;
  acc_t        exp_wr[$], exp_rd[$];
  bit          exp_done, fin_seen;
  logic [1:0]  exp_code;
  logic [15:0] exp_words;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected outcome of a whole frame, straight from the frame rules
  task automatic model(input bq_t b, input bit frc);
    int n, base, cnt;
    bit rng;
    logic [7:0] x;
    logic [15:0] wx;
    acc_t e;
    n    = b.size();
    base = int'({b[0], b[1]});
    cnt  = int'({b[2], b[3]});
    x = 8'h00;
    for (int i = 0; i < n - 1; i++) x ^= b[i];
    exp_wr.delete();
    exp_rd.delete();
    wx  = 16'h0000;
    rng = (base + cnt > DEPTH);
    if (!rng)
      for (int k = 0; k < cnt; k++) begin
        e.a = 16'(base + k);
        e.d = {b[4 + 2*k], b[5 + 2*k]};
        wx ^= e.d;
        exp_wr.push_back(e);
      end
    exp_code  = rng ? 2'd1 : (b[n-1] != x) ? 2'd2 : 2'd0;
    exp_words = rng ? 16'd0 : 16'(cnt);
`ifdef LOADER_VERIFY_EN
    if (exp_code == 2'd0 && cnt != 0) begin
      for (int k = 0; k < cnt; k++) begin
        e.a = 16'(base + k);
        e.d = 16'h0000;
        exp_rd.push_back(e);
      end
      if (frc && wx != 16'h0000) exp_code = 2'd3;
    end
`else
    if (frc) exp_rd.delete();
`endif
    exp_done = (exp_code == 2'd0);
  endtask

  always @(negedge clk) if (!rst) begin
    if (mem_write_en) begin
      chk("rdy_in_write", in_ready, 0);
      chk("rd_wr_excl", mem_read_en, 0);
      if (exp_wr.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        chk("wr_addr", mem_address, exp_wr[0].a);
        chk("wr_data", mem_wdata, exp_wr[0].d);
        void'(exp_wr.pop_front());
      end
    end
    if (mem_read_en) begin
      n_reads++;
      chk("rdy_in_read", in_ready, 0);
      if (exp_rd.size() == 0) chk("unexpected_read", 1, 0);
      else begin
        chk("rd_addr", mem_address, exp_rd[0].a);
        void'(exp_rd.pop_front());
      end
    end
    if (done || error) begin
      chk("done", done, exp_done);
      chk("error", error, !exp_done);
      chk("err_code", err_code, exp_code);
      chk("words_written", words_written, exp_words);
      chk("busy_at_fin", busy, 0);
      fin_seen = 1'b1;
    end
  end

  task automatic send(input bq_t b, input bit tog);
    int i = 0, cyc = 0;
    bit bchk = 1'b0;
    while (i < b.size() && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (i > 0 && !bchk) begin
        chk("busy_in_frame", busy, 1);
        chk("code_cleared", err_code, 0);
        bchk = 1'b1;
      end
      in_valid = tog ? cyc[0] : 1'b1;
      in_data  = b[i];
      if (in_valid && in_ready) i++;
    end
    if (cyc >= 2000) chk("send_timeout", 1, 0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input bq_t b, input bit tog, input bit frc);
    int w = 0;
    model(b, frc);
    force_rd = frc;
    fin_seen = 1'b0;
    send(b, tog);
    while (!fin_seen && w < 40) begin
      @(posedge clk);
      w++;
    end
    chk("fin_seen", fin_seen, 1);
    chk("writes_drained", exp_wr.size(), 0);
    chk("reads_drained", exp_rd.size(), 0);
    @(negedge clk);
    chk("code_held", err_code, exp_code);
    chk("idle_busy", busy, 0);
    force_rd = 1'b0;
  endtask

  function automatic bq_t build(input int base, input int cnt, input bit bad);
    bq_t b;
    logic [7:0] x;
    logic [15:0] bs, cn;
    bs = 16'(base);
    cn = 16'(cnt);
    b = {bs[15:8], bs[7:0], cn[15:8], cn[7:0]};
    for (int k = 0; k < 2*cnt; k++) b.push_back(8'($urandom_range(0, 255)));
    x = 8'h00;
    foreach (b[i]) x ^= b[i];
    if (bad) x ^= 8'(1 << $urandom_range(0, 7));
    b.push_back(x);
    return b;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t b1, b;
    int base, cnt;
    in_valid = 1'b0;
    in_data  = 8'h00;
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'h0000;
    #1 rst = 1'b1;
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done | error, 0);
    chk("rst_wr_en", mem_write_en | mem_read_en, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_code_words", {err_code, words_written}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_rst_ready", in_ready, 1);

    b1 = {8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h52};
    model(b1, 1'b0);
    chk("model_wr0", {exp_wr[0].a, exp_wr[0].d}, 32'h0010_1234);
    chk("model_wr1", {exp_wr[1].a, exp_wr[1].d}, 32'h0011_ABCD);
    chk("model_code", exp_code, 0);
    run_frame(b1, 1'b0, 1'b0);
    chk("case1_mem", {mem[16], mem[17]}, 32'h1234_ABCD);
    chk("case1_words", words_written, 2);

    b = {8'h03, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hBA};
    run_frame(b, 1'b0, 1'b0);
    chk("range_code", err_code, 1);
    chk("range_words", words_written, 0);

    mem[16] = 16'h0000; mem[17] = 16'h0000;
    b = b1; b[8] = 8'h53;
    run_frame(b, 1'b0, 1'b0);
    chk("chk_code", err_code, 2);
    chk("chk_mem_kept", {mem[16], mem[17]}, 32'h1234_ABCD);

    b = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(b, 1'b0, 1'b0);
    chk("zero_words", {err_code, words_written}, 0);

    mem[16] = 16'h0000; mem[17] = 16'h0000;
    run_frame(b1, 1'b1, 1'b0);
    chk("toggle_mem", {mem[16], mem[17]}, 32'h1234_ABCD);

    // reset during the second word's WRITE cycle
    model(b1, 1'b0);
    b = b1; void'(b.pop_back());
    send(b, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("midrst_outputs", {in_ready, busy, done, error, mem_write_en, mem_read_en}, 0);
    chk("midrst_addr", mem_address, 0);
    chk("midrst_code_words", {err_code, words_written}, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_wr.delete();
    mem[16] = 16'h0000; mem[17] = 16'h0000;
    run_frame(b1, 1'b0, 1'b0);
    chk("after_rst_mem", {mem[16], mem[17]}, 32'h1234_ABCD);

    run_frame(build(DEPTH - 2, 2, 1'b0), 1'b0, 1'b0);
    chk("edge_fit_code", err_code, 0);
    run_frame(build(DEPTH - 1, 2, 1'b0), 1'b0, 1'b0);
    chk("edge_over_code", err_code, 1);

`ifdef LOADER_VERIFY_EN
    n_reads = 0;
    run_frame(b1, 1'b0, 1'b1);
    chk("verify_forced_reads", n_reads, 2);
    chk("verify_forced_code", err_code, 3);
    run_frame(b1, 1'b0, 1'b0);
    chk("verify_clean_code", err_code, 0);
`endif

    for (int t = 0; t < 30; t++) begin
      cnt = $urandom_range(0, 6);
      if ($urandom_range(0, 4) == 0) base = DEPTH - cnt + $urandom_range(1, 3);
      else base = $urandom_range(0, DEPTH - cnt);
      run_frame(build(base, cnt, $urandom_range(0, 4) == 0), $urandom_range(0, 1) == 1,
                $urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
